// File: rtl/dual_instr_buffer.sv
// dual_instr_buffer: FIFO that accepts two instructions per cycle from the front end and presents two in-order instructions per cycle to the issue queue.
// Defining IB_PERF_CNT_EN adds saturating stall/empty/full cycle counters.
module dual_instr_buffer #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 128
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [1:0]                   in_valid,
   input  logic [1:0][DATA_W-1:0]       in_instr,
   output logic                         in_ready,
   output logic [1:0]                   valid_D,
   output logic [1:0][DATA_W-1:0]       instr_D,
   input  logic                         allowin_I,
`ifdef IB_PERF_CNT_EN
   output logic [31:0]                  perf_stall_cycles,
   output logic [31:0]                  perf_empty_cycles,
   output logic [31:0]                  perf_full_cycles,
`endif
   output logic [$clog2(DEPTH):0]       count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0] CNT_MAX  = (AW+1)'(DEPTH);
   localparam logic [AW:0] PUSH_LIM = (AW+1)'(DEPTH - 2);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     head_q, head_d, tail_q, tail_d, head1, tail1;
   logic [AW:0]       count_q, count_d;
   logic [1:0]        push_n, pop_n;
   logic              clr;
   assign count = count_q;
   // Occupancy-based flags only: no same-cycle pop credit toward in_ready.
   always_comb begin
      clr        = rst | flush;
      in_ready   = count_q <= PUSH_LIM;
      valid_D[0] = count_q >= CNT_ONE;
      valid_D[1] = count_q > CNT_ONE;
      head1      = head_q + 1'b1;
      tail1      = tail_q + 1'b1;
      instr_D[0] = valid_D[0] ? mem_q[head_q] : '0;
      instr_D[1] = valid_D[1] ? mem_q[head1] : '0;
      push_n     = !in_ready ? 2'd0 : in_valid == 2'b11 ? 2'd2 : in_valid == 2'b01 ? 2'd1 : 2'd0;
      pop_n      = allowin_I ? {1'b0, valid_D[0]} + {1'b0, valid_D[1]} : 2'd0;
      head_d     = head_q + AW'(pop_n);
      tail_d     = tail_q + AW'(push_n);
      count_d    = count_q + (AW+1)'(push_n) - (AW+1)'(pop_n);
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_n != 2'd0) mem_q[tail_q] <= in_instr[0];
         if (push_n == 2'd2) mem_q[tail1] <= in_instr[1];
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) assert (count_q <= CNT_MAX);
   end
`ifdef IB_PERF_CNT_EN
   logic [31:0] stall_q, empty_q, full_q;
   assign perf_stall_cycles = stall_q;
   assign perf_empty_cycles = empty_q;
   assign perf_full_cycles  = full_q;
   // Counters saturate and survive flush; only rst clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         empty_q <= '0;
         full_q  <= '0;
      end else begin
         if (valid_D[0] && !allowin_I && stall_q != '1) stall_q <= stall_q + 32'd1;
         if (count_q == '0 && empty_q != '1) empty_q <= empty_q + 32'd1;
         if (!in_ready && full_q != '1) full_q <= full_q + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_dual_instr_buffer.sv
// tb_dual_instr_buffer: directed vector table plus hand sequences for wrap, flush, reset and perf counters.
module tb_dual_instr_buffer;
   localparam int DEPTH  = 16;
   localparam int DATA_W = 128;
   typedef logic [DATA_W-1:0] d_t;
   typedef struct {
      logic r, f;
      logic [1:0] iv;
      d_t d0, d1;
      logic al;
      int cnt;
      logic [1:0] vd;
      d_t e0, e1;
      logic rdy;
   } vec_t;
   logic clk = 0;
   logic rst, flush, allowin_I, in_ready;
   logic [1:0] in_valid, valid_D;
   logic [1:0][DATA_W-1:0] in_instr, instr_D;
   logic [$clog2(DEPTH):0] count;
`ifdef IB_PERF_CNT_EN
   logic [31:0] perf_stall_cycles, perf_empty_cycles, perf_full_cycles;
`endif
   int tests = 0, fails = 0;
   vec_t tv[$];
   dual_instr_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
      .in_ready(in_ready), .valid_D(valid_D), .instr_D(instr_D), .allowin_I(allowin_I),
`ifdef IB_PERF_CNT_EN
      .perf_stall_cycles(perf_stall_cycles), .perf_empty_cycles(perf_empty_cycles),
      .perf_full_cycles(perf_full_cycles),
`endif
      .count(count)
   );
   always #5 clk = ~clk;
   function automatic d_t tg(int n);
      return {32'(n), 64'hF0F0_F0F0_0F0F_0F0F, 32'(n)};
   endfunction
   function automatic void add(logic r, logic f, logic [1:0] iv, d_t d0, d_t d1, logic al,
                               int cnt, logic [1:0] vd, d_t e0, d_t e1, logic rdy);
      tv.push_back('{r, f, iv, d0, d1, al, cnt, vd, e0, e1, rdy});
   endfunction
   task automatic chk(string name, d_t act, d_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic apply(logic r, logic f, logic [1:0] iv, d_t d0, d_t d1, logic al);
      rst = r; flush = f; in_valid = iv; in_instr[0] = d0; in_instr[1] = d1; allowin_I = al;
      @(posedge clk);
      #1;
   endtask
   task automatic expect_state(string tag, int cnt, logic [1:0] vd, d_t e0, d_t e1, logic rdy);
      chk({tag, ".count"}, d_t'(count), d_t'(cnt));
      chk({tag, ".valid_D"}, d_t'(valid_D), d_t'(vd));
      chk({tag, ".instr0"}, instr_D[0], e0);
      chk({tag, ".instr1"}, instr_D[1], e1);
      chk({tag, ".in_ready"}, d_t'(in_ready), d_t'(rdy));
   endtask
   initial begin
      d_t z, A, B, C, D, E;
      z = '0; A = tg('hA); B = tg('hB); C = tg('hC); D = tg('hD); E = tg('hE);
      // simple push/pop, single push, pop+push, illegal 2'b10
      add(0, 0, 2'b11, A, B, 0, 2, 2'b11, A, B, 1);
      add(0, 0, 2'b00, z, z, 1, 0, 2'b00, z, z, 1);
      add(0, 0, 2'b01, A, z, 1, 1, 2'b01, A, z, 1);
      add(0, 0, 2'b11, B, C, 1, 2, 2'b11, B, C, 1);
      add(0, 0, 2'b10, D, E, 0, 2, 2'b11, B, C, 1);
      // fill to 15, dropped push, then drain across the read wrap
      for (int k = 0; k < 6; k++) add(0, 0, 2'b11, tg(2*k+1), tg(2*k+2), 0, 4+2*k, 2'b11, B, C, 1);
      add(0, 0, 2'b01, tg(13), z, 0, 15, 2'b11, B, C, 0);
      add(0, 0, 2'b11, tg(99), tg(98), 0, 15, 2'b11, B, C, 0);
      for (int k = 0; k < 6; k++) add(0, 0, 2'b00, z, z, 1, 13-2*k, 2'b11, tg(2*k+1), tg(2*k+2), 1);
      add(0, 0, 2'b00, z, z, 1, 1, 2'b01, tg(13), z, 1);
      add(0, 0, 2'b00, z, z, 1, 0, 2'b00, z, z, 1);
      apply(1, 0, 2'b11, A, B, 1);
      apply(1, 0, 2'b11, A, B, 1);
      rst = 0;
      expect_state("reset", 0, 2'b00, z, z, 1);
      foreach (tv[i]) begin
         apply(tv[i].r, tv[i].f, tv[i].iv, tv[i].d0, tv[i].d1, tv[i].al);
         expect_state($sformatf("vec%0d", i), tv[i].cnt, tv[i].vd, tv[i].e0, tv[i].e1, tv[i].rdy);
      end
      // walk pointers to head=tail=15 with count 0 (head/tail start at 2)
      for (int j = 0; j < 13; j++) begin
         apply(0, 0, 2'b01, tg(200+j), z, 1);
         expect_state($sformatf("walk%0d", j), 1, 2'b01, tg(200+j), z, 1);
      end
      apply(0, 0, 2'b00, z, z, 1);
      expect_state("walk_end", 0, 2'b00, z, z, 1);
      apply(0, 0, 2'b11, tg('h58), tg('h59), 0);
      expect_state("wrap_push", 2, 2'b11, tg('h58), tg('h59), 1);
      apply(0, 0, 2'b11, tg(401), tg(402), 0);
      apply(0, 0, 2'b11, tg(403), tg(404), 0);
      expect_state("pre_flush", 6, 2'b11, tg('h58), tg('h59), 1);
      apply(0, 1, 2'b11, tg(500), tg(501), 1);
      expect_state("flush", 0, 2'b00, z, z, 1);
      apply(0, 0, 2'b01, tg(300), z, 0);
      expect_state("post_flush", 1, 2'b01, tg(300), z, 1);
      apply(1, 0, 2'b11, tg(600), tg(601), 1);
      rst = 0;
      expect_state("mid_rst", 0, 2'b00, z, z, 1);
`ifdef IB_PERF_CNT_EN
      apply(0, 0, 2'b01, A, z, 0);
      for (int j = 0; j < 5; j++) apply(0, 0, 2'b00, z, z, 0);
      chk("perf_stall5", d_t'(perf_stall_cycles), d_t'(5));
      apply(0, 1, 2'b00, z, z, 1);
      apply(0, 0, 2'b00, z, z, 1);
      chk("perf_stall_flush", d_t'(perf_stall_cycles), d_t'(5));
      apply(1, 0, 2'b00, z, z, 1);
      rst = 0;
      chk("perf_stall_rst", d_t'(perf_stall_cycles), d_t'(0));
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
